// File: rtl/dual_port_ram_param_if.sv
// Bus bundle for dual_port_ram_param: two symmetric request/response ports plus
// the shared write/write collision strobe.
interface dual_port_ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  localparam int BE_W = DATA_W / 8;

  logic              en_a;
  logic              we_a;
  logic [BE_W-1:0]   be_a;
  logic [ADDR_W-1:0] adr_a;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] q_a;
  logic              valid_a;

  logic              en_b;
  logic              we_b;
  logic [BE_W-1:0]   be_b;
  logic [ADDR_W-1:0] adr_b;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] q_b;
  logic              valid_b;

  logic              collision;

  modport master (
    output en_a, we_a, be_a, adr_a, data_a,
    output en_b, we_b, be_b, adr_b, data_b,
    input  q_a, valid_a, q_b, valid_b, collision
  );

  modport slave (
    input  en_a, we_a, be_a, adr_a, data_a,
    input  en_b, we_b, be_b, adr_b, data_b,
    output q_a, valid_a, q_b, valid_b, collision
  );
endinterface

// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with byte enables, optional output register,
// per-port read-valid strobes and A-wins write/write collision resolution.
module dual_port_ram_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = 64,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  dual_port_ram_param_if.slave bus
);
  localparam int              BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_inr_a, w_inr_b;
  logic              w_wr_a, w_wr_b;
  logic              w_same, w_coll;
  logic [DATA_W-1:0] w_old_a, w_old_b;
  logic [DATA_W-1:0] w_merge_a, w_merge_b;

  logic [DATA_W-1:0] r_q1_a, r_q1_b;
  logic              r_vld1_a, r_vld1_b, r_coll1;

  assign w_inr_a = {1'b0, bus.adr_a} < DEPTH_L;
  assign w_inr_b = {1'b0, bus.adr_b} < DEPTH_L;
  assign w_wr_a  = bus.en_a & bus.we_a & ~i_rst & w_inr_a;
  assign w_wr_b  = bus.en_b & bus.we_b & ~i_rst & w_inr_b;
  assign w_same  = bus.adr_a == bus.adr_b;
  assign w_coll  = w_wr_a & w_wr_b & w_same;
  assign w_old_a = w_inr_a ? r_mem[bus.adr_a] : '0;
  assign w_old_b = w_inr_b ? r_mem[bus.adr_b] : '0;

  // Both merges see both ports, so on a shared address they agree byte for byte.
  always_comb begin
    w_merge_a = w_old_a;
    w_merge_b = w_old_b;
    for (int i = 0; i < BE_W; i++) begin
      if (w_wr_a && bus.be_a[i])
        w_merge_a[8*i +: 8] = bus.data_a[8*i +: 8];
      else if (w_wr_b && w_same && bus.be_b[i])
        w_merge_a[8*i +: 8] = bus.data_b[8*i +: 8];
      if (w_wr_a && w_same && bus.be_a[i])
        w_merge_b[8*i +: 8] = bus.data_a[8*i +: 8];
      else if (w_wr_b && bus.be_b[i])
        w_merge_b[8*i +: 8] = bus.data_b[8*i +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_b) r_mem[bus.adr_b] <= w_merge_b;
    if (w_wr_a) r_mem[bus.adr_a] <= w_merge_a;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q1_a   <= '0;
      r_q1_b   <= '0;
      r_vld1_a <= 1'b0;
      r_vld1_b <= 1'b0;
      r_coll1  <= 1'b0;
    end else begin
      r_vld1_a <= 1'b0;
      r_vld1_b <= 1'b0;
      r_coll1  <= w_coll;
      if (bus.en_a) begin
        if (!bus.we_a) begin
          r_q1_a   <= w_old_a;
          r_vld1_a <= 1'b1;
        end else if (RD_MODE == 1) begin
          r_q1_a   <= w_merge_a;
          r_vld1_a <= 1'b1;
        end
      end
      if (bus.en_b) begin
        if (!bus.we_b) begin
          r_q1_b   <= w_old_b;
          r_vld1_b <= 1'b1;
        end else if (RD_MODE == 1) begin
          r_q1_b   <= w_merge_b;
          r_vld1_b <= 1'b1;
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_q2_a, r_q2_b;
    logic              r_vld2_a, r_vld2_b, r_coll2;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_q2_a   <= '0;
        r_q2_b   <= '0;
        r_vld2_a <= 1'b0;
        r_vld2_b <= 1'b0;
        r_coll2  <= 1'b0;
      end else begin
        r_vld2_a <= r_vld1_a;
        r_vld2_b <= r_vld1_b;
        r_coll2  <= r_coll1;
        if (r_vld1_a) r_q2_a <= r_q1_a;
        if (r_vld1_b) r_q2_b <= r_q1_b;
      end
    end

    assign bus.q_a       = r_q2_a;
    assign bus.q_b       = r_q2_b;
    assign bus.valid_a   = r_vld2_a;
    assign bus.valid_b   = r_vld2_b;
    assign bus.collision = r_coll2;
  end else begin : g_noreg
    assign bus.q_a       = r_q1_a;
    assign bus.q_b       = r_q1_b;
    assign bus.valid_a   = r_vld1_a;
    assign bus.valid_b   = r_vld1_b;
    assign bus.collision = r_coll1;
  end
endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: u0 is 8-bit/64-deep/NO_CHANGE/no out reg, u1 is
// 16-bit/48-deep/WRITE_FIRST/out reg.
module tb_dual_port_ram_param;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  dual_port_ram_param_if #(.DATA_W(8),  .ADDR_W(6)) b0 ();
  dual_port_ram_param_if #(.DATA_W(16), .ADDR_W(6)) b1 ();

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .RD_MODE(0), .OUT_REG(0)) u0 (
    .i_clk(clk), .i_rst(rst), .bus(b0));
  dual_port_ram_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .RD_MODE(1), .OUT_REG(1)) u1 (
    .i_clk(clk), .i_rst(rst), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.en_a = 1'b0; b0.we_a = 1'b0; b0.be_a = '0; b0.adr_a = '0; b0.data_a = '0;
    b0.en_b = 1'b0; b0.we_b = 1'b0; b0.be_b = '0; b0.adr_b = '0; b0.data_b = '0;
    b1.en_a = 1'b0; b1.we_a = 1'b0; b1.be_a = '0; b1.adr_a = '0; b1.data_a = '0;
    b1.en_b = 1'b0; b1.we_b = 1'b0; b1.be_b = '0; b1.adr_b = '0; b1.data_b = '0;
  endtask

  task automatic test_reset();
    n_total++; if ({b0.q_a, b0.q_b} !== 16'h0) $display("FAIL reset_u0_q got %h want 0", {b0.q_a, b0.q_b}); else n_pass++;
    n_total++; if ({b0.valid_a, b0.valid_b, b0.collision} !== 3'b000) $display("FAIL reset_u0_strobes got %b want 000", {b0.valid_a, b0.valid_b, b0.collision}); else n_pass++;
    n_total++; if ({b1.q_a, b1.q_b} !== 32'h0) $display("FAIL reset_u1_q got %h want 0", {b1.q_a, b1.q_b}); else n_pass++;
    n_total++; if ({b1.valid_a, b1.valid_b, b1.collision} !== 3'b000) $display("FAIL reset_u1_strobes got %b want 000", {b1.valid_a, b1.valid_b, b1.collision}); else n_pass++;
  endtask

  task automatic test_basic();
    idle();
    b0.en_a = 1'b1; b0.we_a = 1'b1; b0.be_a = 1'b1;  b0.adr_a = 6'd5; b0.data_a = 8'h3C;
    b1.en_a = 1'b1; b1.we_a = 1'b1; b1.be_a = 2'b11; b1.adr_a = 6'd5; b1.data_a = 16'h003C;
    tick();
    idle();
    b0.en_b = 1'b1; b0.adr_b = 6'd5;
    b1.en_b = 1'b1; b1.adr_b = 6'd5;
    tick();
    n_total++; if (b0.q_b !== 8'h3C) $display("FAIL basic_u0_q_b got %h want 3c", b0.q_b); else n_pass++;
    n_total++; if (b0.valid_b !== 1'b1) $display("FAIL basic_u0_valid_b got %b want 1", b0.valid_b); else n_pass++;
    n_total++; if (b1.valid_b !== 1'b0) $display("FAIL basic_u1_valid_b_early got %b want 0", b1.valid_b); else n_pass++;
    idle();
    tick();
    n_total++; if ({b0.valid_b, b0.q_b} !== {1'b0, 8'h3C}) $display("FAIL basic_u0_hold got %b/%h want 0/3c", b0.valid_b, b0.q_b); else n_pass++;
    n_total++; if ({b1.valid_b, b1.q_b} !== {1'b1, 16'h003C}) $display("FAIL basic_u1_q_b got %b/%h want 1/003c", b1.valid_b, b1.q_b); else n_pass++;
    tick();
    n_total++; if (b1.valid_b !== 1'b0) $display("FAIL basic_u1_valid_b_pulse got %b want 0", b1.valid_b); else n_pass++;
  endtask

  task automatic test_byte_enable();
    idle();
    b1.en_a = 1'b1; b1.we_a = 1'b1; b1.be_a = 2'b11; b1.adr_a = 6'd2; b1.data_a = 16'hAAAA;
    tick();
    b1.be_a = 2'b01; b1.data_a = 16'h1234;
    tick();
    b1.we_a = 1'b0; b1.be_a = 2'b00;
    tick();
    n_total++; if ({b1.valid_a, b1.q_a} !== {1'b1, 16'hAA34}) $display("FAIL be_write_first got %b/%h want 1/aa34", b1.valid_a, b1.q_a); else n_pass++;
    idle();
    tick();
    n_total++; if ({b1.valid_a, b1.q_a} !== {1'b1, 16'hAA34}) $display("FAIL be_read got %b/%h want 1/aa34", b1.valid_a, b1.q_a); else n_pass++;
    tick();
    n_total++; if (b1.valid_a !== 1'b0) $display("FAIL be_valid_pulse got %b want 0", b1.valid_a); else n_pass++;
  endtask

  task automatic test_rd_mode();
    idle();
    b0.en_a = 1'b1; b0.adr_a = 6'd5;
    tick();
    n_total++; if ({b0.valid_a, b0.q_a} !== {1'b1, 8'h3C}) $display("FAIL rdm_u0_read got %b/%h want 1/3c", b0.valid_a, b0.q_a); else n_pass++;
    b0.we_a = 1'b1; b0.be_a = 1'b1; b0.adr_a = 6'd10; b0.data_a = 8'h77;
    tick();
    n_total++; if ({b0.valid_a, b0.q_a} !== {1'b0, 8'h3C}) $display("FAIL rdm_u0_no_change got %b/%h want 0/3c", b0.valid_a, b0.q_a); else n_pass++;
    idle();
    b0.en_a = 1'b1; b0.adr_a = 6'd10;
    tick();
    n_total++; if (b0.q_a !== 8'h77) $display("FAIL rdm_u0_readback got %h want 77", b0.q_a); else n_pass++;
    idle();
    b1.en_a = 1'b1; b1.we_a = 1'b1; b1.be_a = 2'b11; b1.adr_a = 6'd10; b1.data_a = 16'h0077;
    tick();
    idle();
    tick();
    n_total++; if ({b1.valid_a, b1.q_a} !== {1'b1, 16'h0077}) $display("FAIL rdm_u1_write_first got %b/%h want 1/0077", b1.valid_a, b1.q_a); else n_pass++;
  endtask

  task automatic test_collision();
    idle();
    b0.en_a = 1'b1; b0.we_a = 1'b1; b0.be_a = 1'b1; b0.adr_a = 6'd7; b0.data_a = 8'h11;
    b0.en_b = 1'b1; b0.we_b = 1'b1; b0.be_b = 1'b1; b0.adr_b = 6'd7; b0.data_b = 8'h22;
    tick();
    n_total++; if (b0.collision !== 1'b1) $display("FAIL coll_full got %b want 1", b0.collision); else n_pass++;
    idle();
    b0.en_a = 1'b1; b0.adr_a = 6'd7;
    tick();
    n_total++; if ({b0.collision, b0.q_a} !== {1'b0, 8'h11}) $display("FAIL coll_a_wins got %b/%h want 0/11", b0.collision, b0.q_a); else n_pass++;
    idle();
    b0.en_a = 1'b1; b0.we_a = 1'b1; b0.be_a = 1'b0; b0.adr_a = 6'd7; b0.data_a = 8'h33;
    b0.en_b = 1'b1; b0.we_b = 1'b1; b0.be_b = 1'b1; b0.adr_b = 6'd7; b0.data_b = 8'h22;
    tick();
    n_total++; if (b0.collision !== 1'b1) $display("FAIL coll_be0 got %b want 1", b0.collision); else n_pass++;
    idle();
    b0.en_a = 1'b1; b0.adr_a = 6'd7;
    tick();
    n_total++; if (b0.q_a !== 8'h22) $display("FAIL coll_be0_data got %h want 22", b0.q_a); else n_pass++;
    idle();
    b0.en_a = 1'b1; b0.adr_a = 6'd7;
    b0.en_b = 1'b1; b0.adr_b = 6'd7;
    tick();
    n_total++; if ({b0.collision, b0.q_b} !== {1'b0, 8'h22}) $display("FAIL coll_read_read got %b/%h want 0/22", b0.collision, b0.q_b); else n_pass++;
    idle();
    b0.en_a = 1'b1; b0.we_a = 1'b1; b0.be_a = 1'b1; b0.adr_a = 6'd20; b0.data_a = 8'h01;
    b0.en_b = 1'b1; b0.we_b = 1'b1; b0.be_b = 1'b1; b0.adr_b = 6'd21; b0.data_b = 8'h02;
    tick();
    n_total++; if (b0.collision !== 1'b0) $display("FAIL coll_diff_addr got %b want 0", b0.collision); else n_pass++;
    idle();
    b1.en_a = 1'b1; b1.we_a = 1'b1; b1.be_a = 2'b01; b1.adr_a = 6'd8; b1.data_a = 16'h1111;
    b1.en_b = 1'b1; b1.we_b = 1'b1; b1.be_b = 2'b11; b1.adr_b = 6'd8; b1.data_b = 16'h2222;
    tick();
    n_total++; if (b1.collision !== 1'b0) $display("FAIL coll_u1_early got %b want 0", b1.collision); else n_pass++;
    idle();
    tick();
    n_total++; if (b1.collision !== 1'b1) $display("FAIL coll_u1_aligned got %b want 1", b1.collision); else n_pass++;
    b1.en_a = 1'b1; b1.adr_a = 6'd8;
    tick();
    idle();
    tick();
    n_total++; if (b1.q_a !== 16'h2211) $display("FAIL coll_u1_merge got %h want 2211", b1.q_a); else n_pass++;
  endtask

  task automatic test_cross_port();
    idle();
    b0.en_a = 1'b1; b0.we_a = 1'b1; b0.be_a = 1'b1; b0.adr_a = 6'd9; b0.data_a = 8'h55;
    tick();
    b0.data_a = 8'h66;
    b0.en_b = 1'b1; b0.adr_b = 6'd9;
    tick();
    n_total++; if ({b0.valid_b, b0.q_b} !== {1'b1, 8'h55}) $display("FAIL cross_old got %b/%h want 1/55", b0.valid_b, b0.q_b); else n_pass++;
    idle();
    b0.en_b = 1'b1; b0.adr_b = 6'd9;
    tick();
    n_total++; if (b0.q_b !== 8'h66) $display("FAIL cross_new got %h want 66", b0.q_b); else n_pass++;
  endtask

  task automatic test_back_to_back();
    idle();
    b0.en_a = 1'b1; b0.adr_a = 6'd5;
    tick();
    n_total++; if ({b0.valid_a, b0.q_a} !== {1'b1, 8'h3C}) $display("FAIL b2b_0 got %b/%h want 1/3c", b0.valid_a, b0.q_a); else n_pass++;
    b0.adr_a = 6'd7;
    tick();
    n_total++; if ({b0.valid_a, b0.q_a} !== {1'b1, 8'h22}) $display("FAIL b2b_1 got %b/%h want 1/22", b0.valid_a, b0.q_a); else n_pass++;
    b0.adr_a = 6'd9;
    tick();
    n_total++; if ({b0.valid_a, b0.q_a} !== {1'b1, 8'h66}) $display("FAIL b2b_2 got %b/%h want 1/66", b0.valid_a, b0.q_a); else n_pass++;
    idle();
    tick();
    n_total++; if ({b0.valid_a, b0.q_a} !== {1'b0, 8'h66}) $display("FAIL b2b_idle got %b/%h want 0/66", b0.valid_a, b0.q_a); else n_pass++;
  endtask

  task automatic test_out_of_range();
    idle();
    b1.en_a = 1'b1; b1.we_a = 1'b1; b1.be_a = 2'b11; b1.adr_a = 6'd50; b1.data_a = 16'hBEEF;
    b1.en_b = 1'b1; b1.we_b = 1'b1; b1.be_b = 2'b11; b1.adr_b = 6'd50; b1.data_b = 16'h1234;
    tick();
    idle();
    b1.en_b = 1'b1; b1.adr_b = 6'd5;
    tick();
    n_total++; if (b1.collision !== 1'b0) $display("FAIL oor_no_collision got %b want 0", b1.collision); else n_pass++;
    b1.adr_b = 6'd50;
    tick();
    n_total++; if ({b1.valid_b, b1.q_b} !== {1'b1, 16'h003C}) $display("FAIL oor_prior_read got %b/%h want 1/003c", b1.valid_b, b1.q_b); else n_pass++;
    idle();
    tick();
    n_total++; if ({b1.valid_b, b1.q_b} !== {1'b1, 16'h0000}) $display("FAIL oor_read_zero got %b/%h want 1/0000", b1.valid_b, b1.q_b); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    idle();
    b0.en_a = 1'b1; b0.we_a = 1'b1; b0.be_a = 1'b1; b0.adr_a = 6'd3; b0.data_a = 8'h01;
    b1.en_a = 1'b1; b1.adr_a = 6'd2;
    tick();
    rst = 1'b1;
    idle();
    b0.en_a = 1'b1; b0.we_a = 1'b1; b0.be_a = 1'b1; b0.adr_a = 6'd3; b0.data_a = 8'hEE;
    tick();
    n_total++; if ({b1.valid_a, b1.q_a} !== {1'b0, 16'h0000}) $display("FAIL rst_flush_0 got %b/%h want 0/0000", b1.valid_a, b1.q_a); else n_pass++;
    tick();
    n_total++; if (b1.valid_a !== 1'b0) $display("FAIL rst_flush_1 got %b want 0", b1.valid_a); else n_pass++;
    rst = 1'b0;
    idle();
    b0.en_b = 1'b1; b0.adr_b = 6'd3;
    b1.en_a = 1'b1; b1.adr_a = 6'd2;
    tick();
    n_total++; if ({b0.valid_b, b0.q_b} !== {1'b1, 8'h01}) $display("FAIL rst_write_ignored got %b/%h want 1/01", b0.valid_b, b0.q_b); else n_pass++;
    idle();
    tick();
    n_total++; if ({b1.valid_a, b1.q_a} !== {1'b1, 16'hAA34}) $display("FAIL rst_contents_kept got %b/%h want 1/aa34", b1.valid_a, b1.q_a); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    test_basic();
    test_byte_enable();
    test_rd_mode();
    test_collision();
    test_cross_port();
    test_back_to_back();
    test_out_of_range();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dual_port_ram_param.md
# dual_port_ram_param

Parameterised true dual-port synchronous RAM, the next generation of our fixed 8-bit dual-port RAM. Two independent read/write ports share one storage array on a single clock. It adds configurable width and depth, per-byte write enables, an optional output register stage, per-port read-valid strobes and defined same-address collision behaviour. It sits beside our existing RAM blocks as the general buffer memory for datapath and FIFO designs.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 6: address width.
- DEPTH, 64: number of words; 1 ≤ DEPTH ≤ 2**ADDR_W.
- RD_MODE, 0: same-port write behaviour. 0 = NO_CHANGE (q holds). 1 = WRITE_FIRST (q shows the merged new word).
- OUT_REG, 0: 1 adds one output pipeline register to both ports.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en_a  in  1  port A request enable.
- we_a  in  1  port A write (1) / read (0); qualified by en_a.
- be_a  in  DATA_W/8  port A byte enables for writes; bit i covers data bits [8i+7:8i].
- adr_a  in  ADDR_W  port A address.
- data_a  in  DATA_W  port A write data.
- q_a  out  DATA_W  port A read data.
- valid_a  out  1  one-cycle strobe: q_a carries new data.
- en_b, we_b, be_b, adr_b, data_b, q_b, valid_b: port B, identical to port A.
- collision  out  1  one-cycle strobe: both ports wrote the same address.

## Operation
- Request on a port: en=1 at a rising edge. With en=0 the port is idle, q holds and valid=0.
- Write (we=1): only bytes with be=1 are updated. be=0 writes nothing. A write with no byte enables is still a write for collision purposes.
- Read (we=0): the addressed word is returned and valid pulses.
- Same-port write, RD_MODE=0: q holds its previous value and valid stays 0.
- Same-port write, RD_MODE=1: q = the stored word after the byte merge, and valid pulses.
- Cross-port read/write to the same address in the same cycle: the reader gets the old contents (read-before-write), in both RD_MODEs.
- Write/write to the same address in the same cycle:
  - For each byte, A wins where both be bits are set.
  - Bytes enabled by only one port take that port's data.
  - collision pulses.
- Read/read to the same address: both ports return the same word. This is not a collision.
- Out-of-range address (adr ≥ DEPTH):
  - A write is dropped and does not count toward collision.
  - A read returns all zeros with valid=1.
- Reset:
  - q_a, q_b = 0; valid_a, valid_b = 0; collision = 0; OUT_REG pipeline stage cleared.
  - Array contents are not cleared.
  - Requests presented while rst=1 are ignored, including writes.
- Reset mid-operation: reads still in flight in the pipeline are discarded, and no valid is emitted for them.

## Timing
- Read latency: request at edge N gives q/valid at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
- Full throughput: one request per port per cycle, back-to-back, no stalls.
- valid is high exactly one cycle per returned word. Between returns, q holds the last value.
- A write at edge N is visible to any read issued at edge N+1 or later, on either port.
- collision asserts at edge N+1 for colliding writes at edge N, and also passes through the OUT_REG delay, so it stays aligned with valid.
- Deasserting rst at edge N: a request at edge N+1 is accepted.

## Test plan
- Reset, then check q_a=q_b=0, valid=0, collision=0. Then write A adr 5 = 0x3C and read B adr 5 on the next cycle → q_b=0x3C, valid_b high 1 cycle later (2 cycles with OUT_REG=1).
- Byte enables (DATA_W=16): write 0xAAAA to adr 2, then write 0x1234 with be=2'b01, then read → 0xAA34.
- Write/write collision: A writes 0x11 and B writes 0x22 to adr 7 in the same cycle → collision pulses 1 cycle; a later read gives 0x11. Repeat with be_a=0, be_b=1 (DATA_W=8) → reads 0x22, collision still pulses.
- Cross-port read-during-write: adr 9 holds 0x55; A writes 0x66 while B reads adr 9 → q_b=0x55; the next B read → 0x66.
- RD_MODE: same-port write of 0x77 → q holds and valid=0 (RD_MODE=0), or q=0x77 with valid=1 (RD_MODE=1).
- DEPTH=48, ADDR_W=6: write adr 50 is dropped; read adr 50 → 0 with valid=1. Then assert rst with a read in flight (OUT_REG=1) → no valid emitted; array contents are preserved.
